edge_rasterizer: RTL and testbench
==================================

Name: edge_rasterizer

Overview:
- Parametrised successor to the single-triangle scan rasterizer.
- Accepts one screen-space triangle per valid/ready handshake and walks its bounding box in raster order, one sample per cycle.
- Edge functions are evaluated incrementally (add-only after setup); the box is clipped to the screen.
- For each covered pixel it emits frame-buffer address, integer x/y, the three raw edge values and the doubled area, for the downstream interpolation/depth stage.

Parameters:
- COORD_W, 32, vertex coordinate width (signed fixed point).
- FRAC_BITS, 16, fractional bits in vertex coordinates.
- SCREEN_W, 640, screen width in pixels.
- SCREEN_H, 480, screen height in pixels.
- ADDR_W, 26, frame-buffer address width.
- BYTES_PER_PIX, 8, address stride per pixel.
- EDGE_W, 2*(COORD_W-FRAC_BITS)+4, edge/area accumulator width (signed).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- tri_valid  in  1  triangle presented
- tri_ready  out  1  block can accept a triangle
- x0,y0,x1,y1,x2,y2  in  COORD_W each  vertex coordinates, signed fixed point
- base_addr  in  ADDR_W  frame-buffer base
- pix_valid  out  1  pixel outputs valid
- pix_ready  in  1  downstream accepts pixel
- pix_x, pix_y  out  16 each  integer pixel coordinates
- pix_addr  out  ADDR_W  base + (pix_y*SCREEN_W + pix_x)*BYTES_PER_PIX, truncated to ADDR_W
- pix_e0, pix_e1, pix_e2  out  EDGE_W each  edge values E12, E20, E01 at the pixel (barycentric numerators)
- pix_area  out  EDGE_W  doubled signed area (after orientation fix), constant per triangle
- tri_done  out  1  one-cycle pulse when the triangle finishes

Behaviour:
- Reset, asynchronous and active-low, sets:
  - state = IDLE.
  - pix_valid = 0, tri_done = 0.
  - All pixel outputs = 0.
  - tri_ready = 1 (combinational: state==IDLE).
- Coordinates:
  - Integer vertex = arithmetic shift right by FRAC_BITS (floor).
  - Samples are taken at integer pixel positions.
- Edge functions:
  - Eab(x,y) = (xb-xa)*(y-ya) - (yb-ya)*(x-xa).
  - area = E01(x2,y2).
  - Inside when e0>=0 && e1>=0 && e2>=0; pixels on an edge are covered.
- IDLE: on tri_valid && tri_ready, register the vertices and base_addr, then go to SETUP1.
- SETUP1 (1 cycle):
  - Compute the integer bbox, clipped to [0,SCREEN_W-1] x [0,SCREEN_H-1].
  - Compute per-edge step X = -(yb-ya) and step Y = (xb-xa).
  - Compute area.
- SETUP2 (1 cycle):
  - Evaluate the three edges at (minX,minY); store them as row-start values.
  - If area==0 or the clipped bbox is empty (minX>maxX or minY>maxY), go to DONE.
  - If area<0, negate the edges, steps and area (see Optional Feature). Otherwise go to SCAN.
- SCAN, per cycle:
  - If the current sample is outside, advance without output.
  - If inside:
    - Assert pix_valid with all fields, and hold every field stable until pix_ready.
    - Advance in the cycle pix_valid && pix_ready.
    - With pix_ready held high, throughput is 1 pixel/cycle, with no bubble between consecutive inside pixels.
  - Advance along a row: x+1, e += stepX.
  - Advance to the next row: x=minX, y+1, e = rowstart + stepY.
  - After the last sample (maxX,maxY) is consumed or skipped, go to DONE.
- DONE: tri_done=1 for exactly one cycle, pix_valid=0, then IDLE. A new triangle is accepted no earlier than the cycle after DONE.
- Latency: acceptance to first possible pix_valid = 3 cycles.
- Degenerate or empty triangle: tri_done 3 cycles after acceptance, no pixels.
- tri_valid while busy is ignored (tri_ready=0). The upstream must hold it.
- Reset mid-scan aborts immediately:
  - No tri_done pulse.
  - The pending pixel is dropped.
- Arithmetic:
  - All edge arithmetic is signed, in EDGE_W bits.
  - Overflow is impossible for on-screen-sized inputs and is not checked.

Optional Feature:
- Macro BACKFACE_CULL_EN.
- Defined: a triangle with area<0 (clockwise) is culled. SETUP2 goes to DONE and emits no pixels.
- Undefined: clockwise triangles are orientation-fixed. e0..e2, the steps and the area are negated, so both windings rasterize identically and pix_area is always >0.

Test Plan:
- CCW (0,0),(4,0),(0,4), base 0x100, pix_ready=1 -> 15 pixels (x+y<=4) in raster order:
  - first (0,0) with addr 0x100;
  - (4,0) with addr 0x120;
  - last (0,4) with addr 0x100+2560*8;
  - pix_area=16, then a single tri_done.
- Same triangle with pix_ready toggling 1/0 every cycle -> identical pixel sequence; outputs are held stable while stalled; no pixel is lost or duplicated.
- CW (0,0),(0,4),(4,0):
  - without BACKFACE_CULL_EN -> same 15 pixels, pix_area=16;
  - with BACKFACE_CULL_EN -> zero pixels, tri_done 3 cycles after acceptance.
- Collinear (0,0),(2,2),(5,5) -> no pix_valid, tri_done 3 cycles after acceptance, tri_ready high the following cycle.
- Clip: (-3,-3),(3,-3),(-3,3) -> only pixels with x,y>=0 and x+y<=0, i.e. the single pixel (0,0); then (638,478),(645,478),(638,485) -> only x in 638..639, y in 478..479 covered.
- Reset asserted while stalled mid-triangle -> pix_valid=0 and tri_ready=1 immediately, no tri_done; the next triangle rasterizes correctly.

Source files
------------

// File: rtl/edge_rasterizer.sv
// edge_rasterizer
//   Scan rasterizer for one screen-space triangle at a time. A triangle is
//   taken on a tri_valid/tri_ready handshake. Its integer bounding box is
//   clipped to the screen and walked in raster order, one sample per cycle.
//   The three edge functions are stepped with adds only once setup is done.
//   For each covered sample the block presents the pixel on a valid/ready
//   output. The pixel carries the frame-buffer address, x/y, the raw edge
//   values and the doubled area.
//
// Ports
//   clock, reset            clock; asynchronous active-low reset
//   tri_valid / tri_ready   triangle handshake (ready == idle)
//   x0..y2                  vertex coordinates, signed fixed point (FRAC_BITS)
//   base_addr               frame-buffer base address
//   pix_valid / pix_ready   pixel handshake; fields held while stalled
//   pix_x, pix_y            integer pixel coordinates
//   pix_addr                base + (y*SCREEN_W + x)*BYTES_PER_PIX
//   pix_e0..pix_e2          E12, E20, E01 at the pixel
//   pix_area                doubled signed area (positive once oriented)
//   tri_done                one-cycle pulse when the triangle is finished
//
// Build option
//   BACKFACE_CULL_EN  defined: clockwise triangles are dropped without output.
//                     undefined: clockwise triangles are flipped and drawn.

module edge_rasterizer #(
    parameter int COORD_W       = 32,
    parameter int FRAC_BITS     = 16,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int ADDR_W        = 26,
    parameter int BYTES_PER_PIX = 8,
    parameter int EDGE_W        = 2*(COORD_W-FRAC_BITS)+4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [15:0]        pix_x,
    output logic [15:0]        pix_y,
    output logic [ADDR_W-1:0]  pix_addr,
    output logic [EDGE_W-1:0]  pix_e0,
    output logic [EDGE_W-1:0]  pix_e1,
    output logic [EDGE_W-1:0]  pix_e2,
    output logic [EDGE_W-1:0]  pix_area,
    output logic               tri_done
);
    typedef logic signed [EDGE_W-1:0] edge_t;
    typedef enum logic [2:0] {S_IDLE, S_SETUP1, S_SETUP2, S_SCAN, S_DONE} state_t;

    localparam edge_t MAX_X = edge_t'(SCREEN_W-1);
    localparam edge_t MAX_Y = edge_t'(SCREEN_H-1);
    localparam edge_t ONE   = edge_t'(1);
    localparam logic [ADDR_W-1:0] COL_STRIDE = ADDR_W'(BYTES_PER_PIX);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W*BYTES_PER_PIX);
    localparam logic [ADDR_W-1:0] SCR_W_A    = ADDR_W'(SCREEN_W);

    // Floor to integer pixel units, sign-extended into the edge width.
    function automatic edge_t to_int(input logic [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] s;
        s = $signed(c) >>> FRAC_BITS;
        return edge_t'(s);
    endfunction

    function automatic edge_t min3(input edge_t a, input edge_t b, input edge_t c);
        edge_t m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic edge_t max3(input edge_t a, input edge_t b, input edge_t c);
        edge_t m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Edges are inclusive: zero counts as covered.
    function automatic logic inside3(input edge_t a, input edge_t b, input edge_t c);
        return !a[EDGE_W-1] && !b[EDGE_W-1] && !c[EDGE_W-1];
    endfunction

    state_t              state_q, state_d;
    edge_t               vx_q [3], vx_d [3];
    edge_t               vy_q [3], vy_d [3];
    logic [ADDR_W-1:0]   base_q, base_d;
    edge_t               minx_q, minx_d, maxx_q, maxx_d;
    edge_t               miny_q, miny_d, maxy_q, maxy_d;
    edge_t               step_x_q [3], step_x_d [3];
    edge_t               step_y_q [3], step_y_d [3];
    edge_t               area_q, area_d;
    edge_t               e_q [3], e_d [3];
    edge_t               row_q [3], row_d [3];
    edge_t               x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, row_addr_q, row_addr_d;
    logic                pix_valid_q, pix_valid_d;
    logic                tri_done_q, tri_done_d;

    // Per-edge setup and stepping terms. Edge k runs from vertex (k+1)%3 to (k+2)%3.
    edge_t sx_new [3], sy_new [3], e_origin [3], e_row_next [3], e_col_next [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int A = (gi + 1) % 3;
        localparam int B = (gi + 2) % 3;
        assign sx_new[gi]     = vy_q[A] - vy_q[B];
        assign sy_new[gi]     = vx_q[B] - vx_q[A];
        assign e_origin[gi]   = step_y_q[gi]*(miny_q - vy_q[A]) + step_x_q[gi]*(minx_q - vx_q[A]);
        assign e_row_next[gi] = row_q[gi] + step_y_q[gi];
        assign e_col_next[gi] = e_q[gi] + step_x_q[gi];
    end

    edge_t vx_min, vx_max, vy_min, vy_max, area_calc;
    logic [ADDR_W-1:0] start_addr;
    logic flip, empty_box;

    assign vx_min    = min3(vx_q[0], vx_q[1], vx_q[2]);
    assign vx_max    = max3(vx_q[0], vx_q[1], vx_q[2]);
    assign vy_min    = min3(vy_q[0], vy_q[1], vy_q[2]);
    assign vy_max    = max3(vy_q[0], vy_q[1], vy_q[2]);
    assign area_calc = (vx_q[1] - vx_q[0])*(vy_q[2] - vy_q[0])
                     - (vy_q[1] - vy_q[0])*(vx_q[2] - vx_q[0]);
    assign start_addr = base_q + (ADDR_W'(miny_q)*SCR_W_A + ADDR_W'(minx_q))*COL_STRIDE;
    assign flip       = area_q[EDGE_W-1];
    assign empty_box  = (minx_q > maxx_q) || (miny_q > maxy_q);

    always_comb begin
        state_d     = state_q;
        vx_d        = vx_q;
        vy_d        = vy_q;
        base_d      = base_q;
        minx_d      = minx_q;
        maxx_d      = maxx_q;
        miny_d      = miny_q;
        maxy_d      = maxy_q;
        step_x_d    = step_x_q;
        step_y_d    = step_y_q;
        area_d      = area_q;
        e_d         = e_q;
        row_d       = row_q;
        x_d         = x_q;
        y_d         = y_q;
        addr_d      = addr_q;
        row_addr_d  = row_addr_q;
        pix_valid_d = pix_valid_q;
        tri_done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (tri_valid) begin
                    vx_d[0] = to_int(x0);
                    vy_d[0] = to_int(y0);
                    vx_d[1] = to_int(x1);
                    vy_d[1] = to_int(y1);
                    vx_d[2] = to_int(x2);
                    vy_d[2] = to_int(y2);
                    base_d  = base_addr;
                    state_d = S_SETUP1;
                end
            end
            S_SETUP1: begin
                // Only the low side needs clamping at 0 and only the high side at
                // the screen edge; an off-screen box then comes out with min > max.
                minx_d   = vx_min[EDGE_W-1] ? '0 : vx_min;
                miny_d   = vy_min[EDGE_W-1] ? '0 : vy_min;
                maxx_d   = (vx_max > MAX_X) ? MAX_X : vx_max;
                maxy_d   = (vy_max > MAX_Y) ? MAX_Y : vy_max;
                step_x_d = sx_new;
                step_y_d = sy_new;
                area_d   = area_calc;
                state_d  = S_SETUP2;
            end
            S_SETUP2: begin
                if (area_q == '0 || empty_box) begin
                    state_d    = S_DONE;
                    tri_done_d = 1'b1;
                end
`ifdef BACKFACE_CULL_EN
                else if (flip) begin
                    state_d    = S_DONE;
                    tri_done_d = 1'b1;
                end
`endif
                else begin
                    for (int k = 0; k < 3; k++) begin
                        e_d[k]      = flip ? -e_origin[k] : e_origin[k];
                        row_d[k]    = e_d[k];
                        step_x_d[k] = flip ? -step_x_q[k] : step_x_q[k];
                        step_y_d[k] = flip ? -step_y_q[k] : step_y_q[k];
                    end
                    area_d      = flip ? -area_q : area_q;
                    x_d         = minx_q;
                    y_d         = miny_q;
                    addr_d      = start_addr;
                    row_addr_d  = start_addr;
                    pix_valid_d = inside3(e_d[0], e_d[1], e_d[2]);
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                // The registers always hold the sample on display. They advance when
                // that sample is outside or has just been taken downstream.
                if (!pix_valid_q || pix_ready) begin
                    if (x_q == maxx_q) begin
                        if (y_q == maxy_q) begin
                            pix_valid_d = 1'b0;
                            tri_done_d  = 1'b1;
                            state_d     = S_DONE;
                        end else begin
                            x_d         = minx_q;
                            y_d         = y_q + ONE;
                            e_d         = e_row_next;
                            row_d       = e_row_next;
                            addr_d      = row_addr_q + ROW_STRIDE;
                            row_addr_d  = row_addr_q + ROW_STRIDE;
                            pix_valid_d = inside3(e_row_next[0], e_row_next[1], e_row_next[2]);
                        end
                    end else begin
                        x_d         = x_q + ONE;
                        e_d         = e_col_next;
                        addr_d      = addr_q + COL_STRIDE;
                        pix_valid_d = inside3(e_col_next[0], e_col_next[1], e_col_next[2]);
                    end
                end
            end
            S_DONE: begin
                pix_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            minx_q      <= '0;
            maxx_q      <= '0;
            miny_q      <= '0;
            maxy_q      <= '0;
            area_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            row_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            tri_done_q  <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                vx_q[k]     <= '0;
                vy_q[k]     <= '0;
                step_x_q[k] <= '0;
                step_y_q[k] <= '0;
                e_q[k]      <= '0;
                row_q[k]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            vx_q        <= vx_d;
            vy_q        <= vy_d;
            base_q      <= base_d;
            minx_q      <= minx_d;
            maxx_q      <= maxx_d;
            miny_q      <= miny_d;
            maxy_q      <= maxy_d;
            step_x_q    <= step_x_d;
            step_y_q    <= step_y_d;
            area_q      <= area_d;
            e_q         <= e_d;
            row_q       <= row_d;
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            row_addr_q  <= row_addr_d;
            pix_valid_q <= pix_valid_d;
            tri_done_q  <= tri_done_d;
        end
    end

    assign tri_ready = (state_q == S_IDLE);
    assign pix_valid = pix_valid_q;
    assign pix_x     = 16'(x_q);
    assign pix_y     = 16'(y_q);
    assign pix_addr  = addr_q;
    assign pix_e0    = e_q[0];
    assign pix_e1    = e_q[1];
    assign pix_e2    = e_q[2];
    assign pix_area  = area_q;
    assign tri_done  = tri_done_q;

endmodule

// File: tb/tb_edge_rasterizer.sv
// Directed bench for edge_rasterizer: hand-computed pixel lists per triangle.
module tb_edge_rasterizer;
    localparam int AW = 26;
    localparam int EW = 36;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tri_valid = 1'b0;
    logic          tri_ready;
    logic [31:0]   x0 = '0, y0 = '0, x1 = '0, y1 = '0, x2 = '0, y2 = '0;
    logic [AW-1:0] base_addr = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b0;
    logic [15:0]   pix_x, pix_y;
    logic [AW-1:0] pix_addr;
    logic [EW-1:0] pix_e0, pix_e1, pix_e2, pix_area;
    logic          tri_done;

    always #5 clock = ~clock;

    edge_rasterizer dut (
        .clock(clock), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2), .base_addr(base_addr),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_addr(pix_addr), .pix_e0(pix_e0), .pix_e1(pix_e1), .pix_e2(pix_e2),
        .pix_area(pix_area), .tri_done(tri_done)
    );

    int total = 0;
    int bad   = 0;

    int            ex_x[$], ex_y[$], ex_e0[$], ex_e1[$], ex_e2[$];
    logic [AW-1:0] ex_addr[$];
    logic [AW-1:0] got_addr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] fx(input int v);
        return 32'(v * 65536);
    endfunction

    task automatic clear_exp();
        ex_x.delete(); ex_y.delete(); ex_e0.delete(); ex_e1.delete(); ex_e2.delete();
        ex_addr.delete();
    endtask

    task automatic push_pix(input int x, input int y, input int e0, input int e1, input int e2,
                            input logic [AW-1:0] base);
        ex_x.push_back(x); ex_y.push_back(y);
        ex_e0.push_back(e0); ex_e1.push_back(e1); ex_e2.push_back(e2);
        ex_addr.push_back(base + AW'((y*640 + x)*8));
    endtask

    // CCW 4x4 right triangle: E12 = 16-4x-4y, E20 = 4x, E01 = 4y.
    task automatic exp_ccw(input logic [AW-1:0] base);
        clear_exp();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4 - y; x++)
                push_pix(x, y, 16 - 4*x - 4*y, 4*x, 4*y, base);
    endtask

    task automatic run_tri(input string name, input int ax, input int ay, input int bx,
                           input int by, input int cx, input int cy, input logic [AW-1:0] base,
                           input bit toggle, input int exp_area, input int exp_done);
        int idx, cyc, done_cyc, first_pv;
        bit stalled;
        logic [63:0] s_x, s_y, s_addr, s_e0;
        got_addr.delete();
        @(negedge clock);
        x0 = fx(ax); y0 = fx(ay); x1 = fx(bx); y1 = fx(by); x2 = fx(cx); y2 = fx(cy);
        base_addr = base;
        tri_valid = 1'b1;
        pix_ready = toggle ? 1'b0 : 1'b1;
        @(negedge clock);
        tri_valid = 1'b0;
        check({name, "_busy"}, 64'(tri_ready), 64'(0));
        idx = 0; done_cyc = -1; first_pv = -1; stalled = 0;
        s_x = '0; s_y = '0; s_addr = '0; s_e0 = '0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 400) begin
            if (tri_done) begin
                done_cyc = cyc;
                check({name, "_valid_at_done"}, 64'(pix_valid), 64'(0));
            end else if (pix_valid) begin
                if (first_pv < 0) first_pv = cyc;
                if (stalled) begin
                    check({name, "_hold_x"}, 64'(pix_x), s_x);
                    check({name, "_hold_y"}, 64'(pix_y), s_y);
                    check({name, "_hold_addr"}, 64'(pix_addr), s_addr);
                    check({name, "_hold_e0"}, 64'(pix_e0), s_e0);
                end
                pix_ready = toggle ? cyc[0] : 1'b1;
                if (pix_ready) begin
                    if (idx < ex_x.size()) begin
                        check({name, "_x"}, 64'(pix_x), 64'(ex_x[idx]));
                        check({name, "_y"}, 64'(pix_y), 64'(ex_y[idx]));
                        check({name, "_addr"}, 64'(pix_addr), 64'(ex_addr[idx]));
                        check({name, "_e0"}, 64'(pix_e0), 64'(ex_e0[idx]));
                        check({name, "_e1"}, 64'(pix_e1), 64'(ex_e1[idx]));
                        check({name, "_e2"}, 64'(pix_e2), 64'(ex_e2[idx]));
                        check({name, "_area"}, 64'(pix_area), 64'(exp_area));
                    end else begin
                        check({name, "_extra_pixel"}, 64'(idx), 64'(ex_x.size()));
                    end
                    got_addr.push_back(pix_addr);
                    idx++;
                    stalled = 0;
                end else begin
                    s_x = 64'(pix_x); s_y = 64'(pix_y); s_addr = 64'(pix_addr); s_e0 = 64'(pix_e0);
                    stalled = 1;
                end
            end else begin
                if (stalled) check({name, "_valid_dropped"}, 64'(pix_valid), 64'(1));
                stalled = 0;
                pix_ready = toggle ? cyc[0] : 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        check({name, "_done_seen"}, 64'(done_cyc >= 0), 64'(1));
        check({name, "_npix"}, 64'(idx), 64'(ex_x.size()));
        if (ex_x.size() > 0) check({name, "_first_lat"}, 64'(first_pv), 64'(3));
        if (exp_done >= 0) check({name, "_done_lat"}, 64'(done_cyc), 64'(exp_done));
        @(negedge clock);
        check({name, "_done_single"}, 64'(tri_done), 64'(0));
        check({name, "_ready_after"}, 64'(tri_ready), 64'(1));
        $display("tri %s: pixels=%0d first=%0d done_at=%0d", name, idx, first_pv, done_cyc);
    endtask

    initial begin
        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_tri_done", 64'(tri_done), 64'(0));
        check("rst_tri_ready", 64'(tri_ready), 64'(1));
        check("rst_pix_addr", 64'(pix_addr), 64'(0));
        check("rst_pix_area", 64'(pix_area), 64'(0));
        reset = 1'b1;
        @(negedge clock);

        // CCW triangle, full throughput: 25 samples, DONE 3+25 cycles after accept
        exp_ccw(26'h100);
        run_tri("ccw", 0, 0, 4, 0, 0, 4, 26'h100, 1'b0, 16, 28);
        if (got_addr.size() == 15) begin
            check("ccw_addr_first", 64'(got_addr[0]), 64'h100);
            check("ccw_addr_4_0", 64'(got_addr[4]), 64'h120);
            check("ccw_addr_last", 64'(got_addr[14]), 64'(32'h100 + 2560*8));
        end

        // Same triangle with pix_ready toggling
        exp_ccw(26'h100);
        run_tri("ccw_stall", 0, 0, 4, 0, 0, 4, 26'h100, 1'b1, 16, -1);

        // Clockwise winding: after flip, E12 = 16-4x-4y, E20 = 4y, E01 = 4x
        clear_exp();
`ifndef BACKFACE_CULL_EN
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4 - y; x++)
                push_pix(x, y, 16 - 4*x - 4*y, 4*y, 4*x, 26'h100);
        run_tri("cw", 0, 0, 0, 4, 4, 0, 26'h100, 1'b0, 16, 28);
`else
        run_tri("cw_cull", 0, 0, 0, 4, 4, 0, 26'h100, 1'b0, 16, 3);
`endif

        // Collinear: zero area
        clear_exp();
        run_tri("collinear", 0, 0, 2, 2, 5, 5, 26'h0, 1'b0, 0, 3);

        // Clipped at the top-left corner: only (0,0), edges 0/18/18, area 36
        clear_exp();
        push_pix(0, 0, 0, 18, 18, 26'h40);
        run_tri("clip_lo", -3, -3, 3, -3, -3, 3, 26'h40, 1'b0, 36, 19);

        // Clipped at the bottom-right corner: 2x2 box, area 49
        clear_exp();
        push_pix(638, 478, 49, 0, 0, 26'h0);
        push_pix(639, 478, 42, 7, 0, 26'h0);
        push_pix(638, 479, 42, 0, 7, 26'h0);
        push_pix(639, 479, 35, 7, 7, 26'h0);
        run_tri("clip_hi", 638, 478, 645, 478, 638, 485, 26'h0, 1'b0, 49, 7);

        // Reset while stalled on the first pixel
        @(negedge clock);
        x0 = fx(0); y0 = fx(0); x1 = fx(4); y1 = fx(0); x2 = fx(0); y2 = fx(4);
        base_addr = 26'h100;
        pix_ready = 1'b0;
        tri_valid = 1'b1;
        @(negedge clock);
        tri_valid = 1'b0;
        for (int i = 0; i < 10 && !pix_valid; i++) @(negedge clock);
        check("rst_mid_prevalid", 64'(pix_valid), 64'(1));
        reset = 1'b0;
        #1;
        check("rst_mid_pix_valid", 64'(pix_valid), 64'(0));
        check("rst_mid_tri_ready", 64'(tri_ready), 64'(1));
        check("rst_mid_pix_addr", 64'(pix_addr), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_mid_no_done", 64'(tri_done), 64'(0));
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("rst_after_no_done", 64'(tri_done), 64'(0));
        end
        exp_ccw(26'h200);
        run_tri("after_rst", 0, 0, 4, 0, 0, 4, 26'h200, 1'b0, 16, 28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
